// File: rtl/limn2600_mem_router_if.sv
// CPU request bus between the core and limn2600_mem_router.
// master = CPU side, slave = router side.
interface limn2600_mem_router_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_ce;
  logic                  req_we;
  logic                  req_oe;
  logic [31:0]           req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_rdy;
  logic [DATA_WIDTH-1:0] req_rdata;
  logic                  req_err;

  modport master (
    output req_ce, req_we, req_oe, req_addr, req_wdata,
    input  req_rdy, req_rdata, req_err
  );

  modport slave (
    input  req_ce, req_we, req_oe, req_addr, req_wdata,
    output req_rdy, req_rdata, req_err
  );
endinterface

// File: rtl/limn2600_mem_router.sv
// CPU memory request router: ROM/RAM/NVRAM bank sequencing plus the serial TX FIFO registers.
// Define BUS_TIMEOUT_EN to turn a bank that never answers into a bus error after TIMEOUT_CYCLES.
module limn2600_mem_router #(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  limn2600_mem_router_if.slave  cpu,
  output logic                  rom_ce,
  output logic                  rom_we,
  output logic                  rom_oe,
  output logic [31:0]           rom_addr,
  output logic [DATA_WIDTH-1:0] rom_wdata,
  input  logic                  rom_rdy,
  input  logic [DATA_WIDTH-1:0] rom_rdata,
  output logic                  ram_ce,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [31:0]           ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic                  ram_rdy,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  nv_ce,
  output logic                  nv_we,
  output logic                  nv_oe,
  output logic [31:0]           nv_addr,
  output logic [DATA_WIDTH-1:0] nv_wdata,
  input  logic                  nv_rdy,
  input  logic [DATA_WIDTH-1:0] nv_rdata,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  input  logic                  tx_ready
);
  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] ADDR_SCMD = 32'hF800_0040;
  localparam logic [31:0] ADDR_SDAT = 32'hF800_0044;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;
  // bank selects double as the bit index into ce_q
  typedef enum logic [2:0] {SEL_ROM, SEL_RAM, SEL_NV, SEL_SCMD, SEL_SDAT, SEL_NONE} sel_e;

  state_e                state_q, state_d;
  sel_e                  sel_q, sel_d, sel_w;
  logic [2:0]            ce_q, ce_d;
  logic                  cmd_we_q, cmd_we_d, cmd_oe_q, cmd_oe_d;
  logic [31:0]           cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic                  rdy_q, rdy_d, err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [AW:0]           wr_q, wr_d, rd_q, rd_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            mem_q [FIFO_DEPTH];
  logic                  push, flush, pop, fifo_full, fifo_empty;
  logic                  bank_rdy;
  logic [DATA_WIDTH-1:0] bank_rdata;
`ifdef BUS_TIMEOUT_EN
  localparam int         CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
`endif

  always_comb begin
    if (cpu.req_addr == ADDR_SCMD)             sel_w = SEL_SCMD;
    else if (cpu.req_addr == ADDR_SDAT)        sel_w = SEL_SDAT;
    else if (cpu.req_addr[31:16] == 16'hFFFE)  sel_w = SEL_ROM;
    else if (cpu.req_addr[31:16] == 16'h0000)  sel_w = SEL_RAM;
    else if (cpu.req_addr[31:16] == 16'hF800)  sel_w = SEL_NV;
    else                                       sel_w = SEL_NONE;
  end

  always_comb begin
    bank_rdy   = 1'b0;
    bank_rdata = '0;
    case (sel_q)
      SEL_ROM: begin bank_rdy = rom_rdy; bank_rdata = rom_rdata; end
      SEL_RAM: begin bank_rdy = ram_rdy; bank_rdata = ram_rdata; end
      SEL_NV:  begin bank_rdy = nv_rdy;  bank_rdata = nv_rdata;  end
      default: ;
    endcase
  end

  assign fifo_empty = (wr_q == rd_q);
  assign fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop        = !fifo_empty && tx_ready;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ce_d        = '0;
    cmd_we_d    = 1'b0;
    cmd_oe_d    = 1'b0;
    cmd_addr_d  = '0;
    cmd_wdata_d = '0;
    rdy_d       = 1'b0;
    err_d       = 1'b0;
    rdata_d     = '0;
    ovf_d       = ovf_q;
    push        = 1'b0;
    flush       = 1'b0;
`ifdef BUS_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cpu.req_ce) begin
          case (sel_w)
            SEL_ROM, SEL_RAM, SEL_NV: begin
              if (sel_w == SEL_ROM && cpu.req_we) begin
                state_d = S_DONE;
                rdy_d   = 1'b1;
                err_d   = 1'b1;
              end else begin
                state_d     = S_ISSUE;
                sel_d       = sel_w;
                ce_d        = 3'b001 << sel_w;
                cmd_we_d    = cpu.req_we;
                cmd_oe_d    = cpu.req_oe;
                cmd_addr_d  = cpu.req_addr;
                cmd_wdata_d = cpu.req_wdata;
              end
            end
            SEL_SCMD: begin
              state_d = S_DONE;
              rdy_d   = 1'b1;
              // status is sampled before this request's flush takes effect
              if (cpu.req_oe) begin
                rdata_d = DATA_WIDTH'({ovf_q, fifo_full, fifo_empty});
                ovf_d   = 1'b0;
              end
              flush = cpu.req_we && cpu.req_wdata[0];
            end
            SEL_SDAT: begin
              state_d = S_DONE;
              rdy_d   = 1'b1;
              if (cpu.req_oe) rdata_d = DATA_WIDTH'(32'h0000_FFFF);
              if (cpu.req_we) begin
                if (fifo_full) ovf_d = 1'b1;
                else           push  = 1'b1;
              end
            end
            default: begin
              state_d = S_DONE;
              rdy_d   = 1'b1;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef BUS_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (bank_rdy) begin
          state_d = S_DONE;
          rdy_d   = 1'b1;
          rdata_d = bank_rdata;
        end
`ifdef BUS_TIMEOUT_EN
        else if (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_DONE;
          rdy_d   = 1'b1;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    wr_d = wr_q;
    rd_d = rd_q;
    if (pop)  rd_d = rd_q + 1'b1;
    if (push) wr_d = wr_q + 1'b1;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sel_q       <= SEL_NONE;
      ce_q        <= '0;
      cmd_we_q    <= 1'b0;
      cmd_oe_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rdy_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      ovf_q       <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      ce_q        <= ce_d;
      cmd_we_q    <= cmd_we_d;
      cmd_oe_q    <= cmd_oe_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rdy_q       <= rdy_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      ovf_q       <= ovf_d;
`ifdef BUS_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) mem_q[wr_q[AW-1:0]] <= cpu.req_wdata[7:0];
  end

  assign cpu.req_rdy   = rdy_q;
  assign cpu.req_err   = err_q;
  assign cpu.req_rdata = rdata_q;

  // command fields are only non-zero during ISSUE; ce picks the one bank that sees them
  assign rom_ce    = ce_q[0];
  assign rom_we    = ce_q[0] & cmd_we_q;
  assign rom_oe    = ce_q[0] & cmd_oe_q;
  assign rom_addr  = ce_q[0] ? cmd_addr_q  : '0;
  assign rom_wdata = ce_q[0] ? cmd_wdata_q : '0;
  assign ram_ce    = ce_q[1];
  assign ram_we    = ce_q[1] & cmd_we_q;
  assign ram_oe    = ce_q[1] & cmd_oe_q;
  assign ram_addr  = ce_q[1] ? cmd_addr_q  : '0;
  assign ram_wdata = ce_q[1] ? cmd_wdata_q : '0;
  assign nv_ce     = ce_q[2];
  assign nv_we     = ce_q[2] & cmd_we_q;
  assign nv_oe     = ce_q[2] & cmd_oe_q;
  assign nv_addr   = ce_q[2] ? cmd_addr_q  : '0;
  assign nv_wdata  = ce_q[2] ? cmd_wdata_q : '0;

  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_empty ? 8'h00 : mem_q[rd_q[AW-1:0]];
endmodule
